// File: rtl/output_tile_scheduler_pkg.sv
// Shared definitions for the output tile scheduler: FSM states, tile-grid sizing
// and the edge-trimmed tile count helper also used by the input-side schedulers.
package output_tile_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACK,
        S_RUN,
        S_FIN
    } state_e;

    // Tiles along one dimension (TM for rows, TN for columns).
    function automatic int tiles_per_dim(input int max_dim, input int sys_dim);
        return max_dim / sys_dim;
    endfunction

    // Index width needed to address every tile along one dimension.
    function automatic int tile_idx_w(input int max_dim, input int sys_dim);
        return $clog2(max_dim / sys_dim);
    endfunction

    // Size-minus-one of tile idx: the last tile keeps only the remainder of dim_m1.
    function automatic int unsigned tile_count_m1(input int unsigned dim_m1,
                                                  input int unsigned idx,
                                                  input int unsigned sys_log2);
        int unsigned mask;
        mask = (32'd1 << sys_log2) - 32'd1;
        return (idx == (dim_m1 >> sys_log2)) ? (dim_m1 & mask) : mask;
    endfunction

endpackage

// File: rtl/output_tile_scheduler_tile_counter.sv
// Row-major 2-D tile walker: holds the job dimensions, the current tile indices,
// their trimmed counts and the running write address.
module output_tile_scheduler_tile_counter
    import output_tile_scheduler_pkg::*;
#(
    parameter int DIM_R_W    = 7,
    parameter int DIM_C_W    = 7,
    parameter int CNT_R_W    = 4,
    parameter int CNT_C_W    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int ADDR_STEP  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_i,
    input  logic                          adv_i,
    input  logic [DIM_R_W-1:0]            rows_m1_i,
    input  logic [DIM_C_W-1:0]            cols_m1_i,
    input  logic [ADDR_WIDTH-1:0]         base_i,
    output logic [DIM_R_W-CNT_R_W-1:0]    row_o,
    output logic [DIM_C_W-CNT_C_W-1:0]    col_o,
    output logic [CNT_R_W-1:0]            nr_o,
    output logic [CNT_C_W-1:0]            nc_o,
    output logic [ADDR_WIDTH-1:0]         addr_o,
    output logic                          last_o
);
    localparam int IR_W = DIM_R_W - CNT_R_W;
    localparam int IC_W = DIM_C_W - CNT_C_W;

    logic [DIM_R_W-1:0]    rows_q, rows_d;
    logic [DIM_C_W-1:0]    cols_q, cols_d;
    logic [IR_W-1:0]       row_q, row_d;
    logic [IC_W-1:0]       col_q, col_d;
    logic [CNT_R_W-1:0]    nr_q, nr_d;
    logic [CNT_C_W-1:0]    nc_q, nc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [IR_W-1:0]       last_row;
    logic [IC_W-1:0]       last_col;

    assign last_row = rows_q[DIM_R_W-1:CNT_R_W];
    assign last_col = cols_q[DIM_C_W-1:CNT_C_W];

    always_comb begin
        rows_d = rows_q;
        cols_d = cols_q;
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        if (load_i) begin
            rows_d = rows_m1_i;
            cols_d = cols_m1_i;
            row_d  = '0;
            col_d  = '0;
            addr_d = base_i;
        end else if (adv_i) begin
            if (col_q == last_col) begin
                col_d = '0;
                row_d = row_q + IR_W'(1);
            end else begin
                col_d = col_q + IC_W'(1);
            end
            addr_d = addr_q + ADDR_WIDTH'(ADDR_STEP);
        end
        // Counts are computed from the next indices so they register alongside them.
        nr_d = CNT_R_W'(tile_count_m1(32'(rows_d), 32'(row_d), CNT_R_W));
        nc_d = CNT_C_W'(tile_count_m1(32'(cols_d), 32'(col_d), CNT_C_W));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_q <= '0;
            cols_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            nr_q   <= '0;
            nc_q   <= '0;
            addr_q <= '0;
        end else begin
            rows_q <= rows_d;
            cols_q <= cols_d;
            row_q  <= row_d;
            col_q  <= col_d;
            nr_q   <= nr_d;
            nc_q   <= nc_d;
            addr_q <= addr_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign nr_o   = nr_q;
    assign nc_o   = nc_q;
    assign addr_o = addr_q;
    assign last_o = (row_q == last_row) && (col_q == last_col);

endmodule

// File: rtl/output_tile_scheduler.sv
// Walks every systolic-array tile of the output matrix and hands each one to the
// output-store controller with a start / done(fall, rise) handshake.
module output_tile_scheduler
    import output_tile_scheduler_pkg::*;
#(
    parameter int MAX_OUT_ROWS = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                                                     clk,
    input  logic                                                     reset,
    input  logic                                                     go,
    input  logic [$clog2(MAX_OUT_ROWS)-1:0]                          out_rows_m1,
    input  logic [$clog2(MAX_OUT_COLS)-1:0]                          out_cols_m1,
    input  logic [ADDR_WIDTH-1:0]                                    base_addr,
    input  logic                                                     activate_cfg,
    input  logic                                                     clear_cfg,
    output logic                                                     busy,
    output logic                                                     job_done,
    output logic                                                     oc_start,
    input  logic                                                     oc_done,
    output logic [$clog2(tiles_per_dim(MAX_OUT_ROWS, SYS_ARR_ROWS))-1:0] submat_row,
    output logic [$clog2(tiles_per_dim(MAX_OUT_COLS, SYS_ARR_COLS))-1:0] submat_col,
    output logic [$clog2(SYS_ARR_ROWS)-1:0]                          num_rows_read,
    output logic [$clog2(SYS_ARR_COLS)-1:0]                          num_cols_read,
    output logic [ADDR_WIDTH-1:0]                                    wr_base_addr,
    output logic                                                     activate,
    output logic                                                     clear_after
);
    localparam int DIM_R_W = $clog2(MAX_OUT_ROWS);
    localparam int DIM_C_W = $clog2(MAX_OUT_COLS);
    localparam int CNT_R_W = $clog2(SYS_ARR_ROWS);
    localparam int CNT_C_W = $clog2(SYS_ARR_COLS);

    state_e state_q;
    logic   busy_q, job_done_q, oc_start_q, activate_q, clear_q;
    logic   load, adv, last_tile;

    assign load = (state_q == S_IDLE) && go;
    assign adv  = (state_q == S_RUN) && oc_done && !last_tile;

    output_tile_scheduler_tile_counter #(
        .DIM_R_W    (DIM_R_W),
        .DIM_C_W    (DIM_C_W),
        .CNT_R_W    (CNT_R_W),
        .CNT_C_W    (CNT_C_W),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_STEP  (SYS_ARR_ROWS)
    ) u_tile_counter (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load),
        .adv_i     (adv),
        .rows_m1_i (out_rows_m1),
        .cols_m1_i (out_cols_m1),
        .base_i    (base_addr),
        .row_o     (submat_row),
        .col_o     (submat_col),
        .nr_o      (num_rows_read),
        .nc_o      (num_cols_read),
        .addr_o    (wr_base_addr),
        .last_o    (last_tile)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            job_done_q <= 1'b0;
            oc_start_q <= 1'b0;
            activate_q <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (go) begin
                    state_q    <= S_ISSUE;
                    busy_q     <= 1'b1;
                    oc_start_q <= 1'b1;
                    activate_q <= activate_cfg;
                    clear_q    <= clear_cfg;
                end
                S_ISSUE: begin
                    oc_start_q <= 1'b0;
                    state_q    <= S_ACK;
                end
                // Low done means the controller has taken the start.
                S_ACK: if (!oc_done) state_q <= S_RUN;
                S_RUN: if (oc_done) begin
                    if (last_tile) begin
                        state_q    <= S_FIN;
                        job_done_q <= 1'b1;
                    end else begin
                        state_q    <= S_ISSUE;
                        oc_start_q <= 1'b1;
                    end
                end
                S_FIN: begin
                    job_done_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign job_done    = job_done_q;
    assign oc_start    = oc_start_q;
    assign activate    = activate_q;
    assign clear_after = clear_q;

endmodule

// File: tb/tb_output_tile_scheduler.sv
// Bench for output_tile_scheduler: a behavioural output controller plus a tile-list
// model of each job, compared against every oc_start the scheduler issues.
module tb_output_tile_scheduler;
    logic       clk = 1'b0;
    logic       reset, go, activate_cfg, clear_cfg, oc_done;
    logic [6:0] out_rows_m1, out_cols_m1;
    logic [7:0] base_addr;
    logic       busy, job_done, oc_start, activate, clear_after;
    logic [2:0] submat_row, submat_col;
    logic [3:0] num_rows_read, num_cols_read;
    logic [7:0] wr_base_addr;

    int total = 0;
    int bad   = 0;
    int ctl_hold = 0;
    int ctl_busy = 2;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] c;
        logic [3:0] nr;
        logic [3:0] nc;
        logic [7:0] addr;
        logic       act;
        logic       clr;
    } tile_t;

    output_tile_scheduler dut (
        .clk(clk), .reset(reset), .go(go),
        .out_rows_m1(out_rows_m1), .out_cols_m1(out_cols_m1), .base_addr(base_addr),
        .activate_cfg(activate_cfg), .clear_cfg(clear_cfg),
        .busy(busy), .job_done(job_done), .oc_start(oc_start), .oc_done(oc_done),
        .submat_row(submat_row), .submat_col(submat_col),
        .num_rows_read(num_rows_read), .num_cols_read(num_cols_read),
        .wr_base_addr(wr_base_addr), .activate(activate), .clear_after(clear_after)
    );

    always #5 clk = ~clk;

    // Output controller: done stays high ctl_hold cycles after a start, then low ctl_busy cycles.
    initial begin
        oc_done = 1'b1;
        forever begin
            @(negedge clk);
            if (oc_start === 1'b1 && reset === 1'b0) begin
                repeat (ctl_hold) @(negedge clk);
                oc_done = 1'b0;
                repeat (ctl_busy) @(negedge clk);
                oc_done = 1'b1;
            end
        end
    end

    task automatic run_job(input int rm, input int cm, input int b, input int a, input int c,
                           input int hold, input bit inject, input string name);
        tile_t exp[$];
        tile_t got[$];
        tile_t t;
        int    cyc, k, nexp;
        bit    seen_done;
        k = 0;
        for (int r = 0; r <= rm / 16; r++) begin
            for (int cc = 0; cc <= cm / 16; cc++) begin
                t.r    = r[2:0];
                t.c    = cc[2:0];
                t.nr   = (r == rm / 16) ? 4'(rm % 16) : 4'd15;
                t.nc   = (cc == cm / 16) ? 4'(cm % 16) : 4'd15;
                t.addr = 8'((b + 16 * k) % 256);
                t.act  = a[0];
                t.clr  = c[0];
                exp.push_back(t);
                k++;
            end
        end
        ctl_hold = hold;
        ctl_busy = $urandom_range(2, 5);
        @(negedge clk);
        go = 1'b1;
        out_rows_m1 = rm[6:0]; out_cols_m1 = cm[6:0]; base_addr = b[7:0];
        activate_cfg = a[0]; clear_cfg = c[0];
        cyc = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                go = 1'b0;
                total++;
                if ({busy, oc_start} !== 2'b11)
                    begin bad++; $display("FAIL %s first_cycle busy,oc_start=%b want 11", name, {busy, oc_start}); end
                out_rows_m1 = 7'($urandom); out_cols_m1 = 7'($urandom); base_addr = 8'($urandom);
                activate_cfg = 1'($urandom); clear_cfg = 1'($urandom);
            end
            if (inject && cyc == 12) begin
                go = 1'b1;
                out_rows_m1 = 7'($urandom); out_cols_m1 = 7'($urandom); base_addr = 8'($urandom);
                activate_cfg = ~a[0]; clear_cfg = ~c[0];
            end
            if (inject && cyc == 13) go = 1'b0;
            if (oc_start)
                got.push_back({submat_row, submat_col, num_rows_read, num_cols_read,
                               wr_base_addr, activate, clear_after});
            if (job_done) seen_done = 1'b1;
        end
        total++;
        if (!seen_done) begin
            bad++; $display("FAIL %s job_done_timeout got=0 want=1", name);
        end else begin
            total++;
            if (oc_done !== 1'b1)
                begin bad++; $display("FAIL %s done_before_ctrl oc_done=%b want 1", name, oc_done); end
        end
        total++;
        if (got.size() != exp.size())
            begin bad++; $display("FAIL %s tile_count got=%0d want=%0d", name, got.size(), exp.size()); end
        @(negedge clk);
        total++;
        if ({busy, job_done} !== 2'b00)
            begin bad++; $display("FAIL %s after_done busy,job_done=%b want 00", name, {busy, job_done}); end
        nexp = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < nexp; i++) begin
            total++;
            if (got[i] !== exp[i])
                begin bad++; $display("FAIL %s tile%0d got=%h want=%h", name, i, got[i], exp[i]); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; go = 1'b0; out_rows_m1 = '0; out_cols_m1 = '0; base_addr = '0;
        activate_cfg = 1'b0; clear_cfg = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, job_done, oc_start, submat_row, submat_col, num_rows_read, num_cols_read,
             wr_base_addr, activate, clear_after} !== '0)
            begin bad++; $display("FAIL reset_outputs got nonzero want 0 (wba=%h)", wr_base_addr); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, oc_start} !== 2'b00)
            begin bad++; $display("FAIL idle_after_reset busy,oc_start=%b want 00", {busy, oc_start}); end
    endtask

    task automatic test_multi();
        run_job(39, 19, 'h10, 1, 0, 0, 1'b0, "multi");
    endtask

    task automatic test_single();
        run_job(0, 0, 'h10, 0, 1, 0, 1'b0, "single");
    endtask

    task automatic test_slow_ctrl();
        run_job(39, 19, 'h10, 1, 1, 3, 1'b0, "slow");
    endtask

    task automatic test_addr_wrap();
        run_job(15, 31, 'hF0, 0, 0, 1, 1'b0, "wrap");
    endtask

    task automatic test_go_while_busy();
        run_job(39, 19, 'h10, 1, 0, 1, 1'b1, "go_busy");
    endtask

    task automatic test_reset_mid();
        int starts, cyc;
        ctl_hold = 0; ctl_busy = 6;
        @(negedge clk);
        go = 1'b1; out_rows_m1 = 7'd39; out_cols_m1 = 7'd19; base_addr = 8'h10;
        activate_cfg = 1'b1; clear_cfg = 1'b1;
        starts = 0; cyc = 0;
        while (starts < 3 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            go = 1'b0;
            if (oc_start) starts++;
        end
        total++;
        if (starts != 3) begin bad++; $display("FAIL reset_mid reach_tile2 got=%0d want=3", starts); end
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({busy, job_done, oc_start, submat_row, submat_col, num_rows_read, num_cols_read,
             wr_base_addr, activate, clear_after} !== '0)
            begin bad++; $display("FAIL reset_mid outputs nonzero (busy=%b wba=%h) want 0", busy, wr_base_addr); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid idle busy=%b want 0", busy); end
        run_job(39, 19, 'h10, 0, 1, 0, 1'b0, "restart");
    endtask

    task automatic test_random();
        for (int j = 0; j < 4; j++)
            run_job($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 255),
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3), 1'b0, "random");
    endtask

    initial begin
        test_reset();
        test_multi();
        test_single();
        test_slow_ctrl();
        test_addr_wrap();
        test_go_while_busy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
